// File: rtl/dmem_pkg.sv
// Shared types, constants and lane-mask helper for the data-memory responder.
package dmem_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBYTES = XLEN / 8;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // RISC-V load/store size codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Latched request payload
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [2:0]      funct3;
    } dmem_req_t;

    // Byte-enable mask for a given size code and byte offset; zero for illegal sizes
    function automatic logic [NBYTES-1:0] lane_mask(input logic [2:0] funct3, input logic [1:0] a);
        logic [NBYTES-1:0] m;
        m = '0;
        case (funct3)
            F3_B, F3_BU: m = 4'b0001 << a;
            F3_H, F3_HU: m = 4'b0011 << a;
            F3_W:        m = 4'b1111;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Combinational byte-lane steering: store replication, load right-justification, size/alignment flags.
module dmem_lane_steer
    import dmem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rword,
    output logic [NBYTES-1:0] be_c,
    output logic [XLEN-1:0]   wdata_rep_c,
    output logic [XLEN-1:0]   rdata_rj_c,
    output logic              misalign_c,
    output logic              illegal_c
);

    logic [XLEN-1:0] shifted;

    // Decode size into lane mask, replicated store data and right-justified load data
    always_comb begin
        be_c        = lane_mask(funct3, addr_lo);
        wdata_rep_c = wdata;
        rdata_rj_c  = '0;
        misalign_c  = 1'b0;
        illegal_c   = 1'b0;
        shifted     = rword >> {addr_lo, 3'b000};
        case (funct3)
            F3_B, F3_BU: begin
                wdata_rep_c = {4{wdata[7:0]}};
                rdata_rj_c  = {24'd0, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                wdata_rep_c = {2{wdata[15:0]}};
                rdata_rj_c  = {16'd0, shifted[15:0]};
                misalign_c  = addr_lo[0];
            end
            F3_W: begin
                rdata_rj_c  = rword;
                misalign_c  = |addr_lo;
            end
            default: begin
                illegal_c   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with byte-lane steering and a word-organised array.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [2:0]      req_funct3,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    dmem_req_t           req_q, req_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [XLEN-1:0]     mem_q [DEPTH];

    dmem_req_t           cur_c;
    logic [IDX_W-1:0]    idx_c;
    logic [XLEN-1:0]     rword_c;
    logic                oor_c;
    logic                err_c;
    logic                commit_c;
    logic [NBYTES-1:0]   be_c;
    logic [XLEN-1:0]     wdata_rep_c;
    logic [XLEN-1:0]     rdata_rj_c;
    logic                misalign_c;
    logic                illegal_c;

    // Request being committed: live inputs while idle (single-cycle latency path), else the latched copy
    always_comb begin
        cur_c = req_q;
        if (state_q == ST_IDLE) begin
            cur_c.we     = req_we;
            cur_c.addr   = req_addr;
            cur_c.wdata  = req_wdata;
            cur_c.funct3 = req_funct3;
        end
        idx_c   = cur_c.addr[IDX_W+1:2];
        oor_c   = cur_c.addr[XLEN-1:2] >= 30'(DEPTH);
        rword_c = mem_q[idx_c];
        err_c   = misalign_c | illegal_c | oor_c;
    end

    dmem_lane_steer u_steer (
        .funct3      (cur_c.funct3),
        .addr_lo     (cur_c.addr[1:0]),
        .wdata       (cur_c.wdata),
        .rword       (rword_c),
        .be_c        (be_c),
        .wdata_rep_c (wdata_rep_c),
        .rdata_rj_c  (rdata_rj_c),
        .misalign_c  (misalign_c),
        .illegal_c   (illegal_c)
    );

    // Next-state, latency counter and response computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        commit_c    = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d = cur_c;
                    if (LATENCY == 1) begin
                        state_d  = ST_RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_RESP;
                    commit_c = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (commit_c) begin
            rsp_err_d   = err_c;
            rsp_rdata_d = (err_c || cur_c.we) ? '0 : rdata_rj_c;
        end
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-enabled array write, only for an error-free store at commit
    always_ff @(posedge clk) begin
        if (!reset && commit_c && cur_c.we && !err_c) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (be_c[i]) begin
                    mem_q[idx_c][8*i +: 8] <= wdata_rep_c[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-addressed reference memory.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks;
    int n_fail;

    logic [7:0] mb [DEPTH*4];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: byte-addressed memory, size from the access width, natural alignment rule
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic err, output logic [31:0] rd);
        int unsigned sz;
        sz  = (f3 == F3_B || f3 == F3_BU) ? 1 : (f3 == F3_H || f3 == F3_HU) ? 2 : 4;
        err = !(f3 == F3_B || f3 == F3_BU || f3 == F3_H || f3 == F3_HU || f3 == F3_W)
              || (addr % sz != 0) || (addr / 4 >= DEPTH);
        rd  = 32'd0;
        if (!err) begin
            for (int i = 0; i < int'(sz); i++) begin
                if (we) mb[addr + 32'(i)] = wdata[8*i +: 8];
                else    rd[8*i +: 8] = mb[addr + 32'(i)];
            end
        end
    endtask

    // One full transaction starting and ending at a negedge with the DUT idle
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input int hold, output logic [31:0] got_d);
        logic        exp_e;
        logic [31:0] exp_d;
        model(we, addr, wdata, f3, exp_e, exp_d);
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        rsp_ready  = 1'($urandom);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        for (int i = 1; i < int'(LAT); i++) begin
            check_eq("rsp_valid_early", 32'(rsp_valid), 32'd0);
            check_eq("req_ready_wait", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        check_eq("rsp_valid_on_time", 32'(rsp_valid), 32'd1);
        check_eq("rsp_err", 32'(rsp_err), 32'(exp_e));
        check_eq("rsp_rdata", rsp_rdata, exp_d);
        check_eq("req_ready_resp", 32'(req_ready), 32'd0);
        got_d     = rsp_rdata;
        rsp_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_addr   = $urandom_range(0, 63) * 4;
            req_wdata  = $urandom;
            req_funct3 = F3_W;
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_rdata", rsp_rdata, exp_d);
            check_eq("hold_err", 32'(rsp_err), 32'(exp_e));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check_eq("req_ready_back", 32'(req_ready), 32'd1);
        rsp_ready = 1'($urandom);
    endtask

    // Store accepted, then reset asserted for two cycles while it waits
    task automatic reset_mid_wait(input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = F3_W;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] addr;
        int unsigned idx;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'd0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset_req_ready", 32'(req_ready), 32'd1);
        check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("reset_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fill the whole array so every later load has a defined reference
        for (int w = 0; w < int'(DEPTH); w++) begin
            run_txn(1'b1, 32'(w) * 4, $urandom, F3_W, 0, got);
        end

        // Directed sequence
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 0, got);
        check_eq("sw_rdata_zero", got, 32'd0);
        run_txn(1'b0, 32'h10, 32'h0, F3_W, 0, got);
        check_eq("lw_deadbeef", got, 32'hDEADBEEF);
        run_txn(1'b1, 32'h11, 32'h000000AA, F3_B, 0, got);
        run_txn(1'b0, 32'h10, 32'h0, F3_W, 0, got);
        check_eq("lw_after_sb", got, 32'hDEADAAEF);
        run_txn(1'b0, 32'h13, 32'h0, F3_BU, 0, got);
        check_eq("lbu_0x13", got, 32'h000000DE);
        run_txn(1'b1, 32'h12, 32'h00001234, F3_H, 0, got);
        run_txn(1'b0, 32'h12, 32'h0, F3_HU, 0, got);
        check_eq("lhu_0x12", got, 32'h00001234);
        run_txn(1'b0, 32'h10, 32'h0, F3_W, 5, got);
        check_eq("lw_after_sh_held", got, 32'h1234AAEF);
        run_txn(1'b0, 32'h12, 32'h0, F3_W, 0, got);
        run_txn(1'b0, 32'h11, 32'h0, F3_H, 0, got);
        run_txn(1'b0, 32'h10, 32'h0, 3'b011, 0, got);
        run_txn(1'b1, 32'h11, 32'hFFFFFFFF, F3_H, 0, got);
        run_txn(1'b1, 32'h10, 32'hFFFFFFFF, 3'b111, 0, got);
        run_txn(1'b0, 32'h10, 32'h0, F3_W, 0, got);
        check_eq("mem_unchanged", got, 32'h1234AAEF);
        run_txn(1'b1, 32'(DEPTH) * 4, 32'hCAFEF00D, F3_W, 0, got);
        run_txn(1'b0, 32'h0, 32'h0, F3_W, 0, got);

        // Reset during WAIT drops the pending store
        reset_mid_wait(32'h20, 32'h55AA55AA);
        run_txn(1'b0, 32'h20, 32'h0, F3_W, 0, got);

        // Randomized traffic around low and top-of-array words
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       idx = DEPTH - 2 + $urandom_range(0, 3);
                1:       idx = $urandom & 32'h3FFF_FFFF;
                default: idx = $urandom_range(0, 15);
            endcase
            addr = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            run_txn(1'($urandom), addr, $urandom, 3'($urandom), ($urandom_range(0, 4) == 0) ? 3 : 0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
